// File: rtl/axi_lite_reg_bridge_if.sv
// AXI4-Lite bundle carrying the AW/W/B/AR/R channels, with master and slave views.
interface AXI_LITE #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32
);
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic [2:0]                  aw_prot;
  logic                        aw_valid;
  logic                        aw_ready;
  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                        w_valid;
  logic                        w_ready;
  logic [1:0]                  b_resp;
  logic                        b_valid;
  logic                        b_ready;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
  logic [2:0]                  ar_prot;
  logic                        ar_valid;
  logic                        ar_ready;
  logic [AXI_DATA_WIDTH-1:0]   r_data;
  logic [1:0]                  r_resp;
  logic                        r_valid;
  logic                        r_ready;

  modport Master (
    output aw_addr, aw_prot, aw_valid, w_data, w_strb, w_valid, b_ready,
           ar_addr, ar_prot, ar_valid, r_ready,
    input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );

  modport Slave (
    input  aw_addr, aw_prot, aw_valid, w_data, w_strb, w_valid, b_ready,
           ar_addr, ar_prot, ar_valid, r_ready,
    output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );
endinterface

// File: rtl/axi_lite_reg_bridge.sv
// AXI4-Lite slave to single-beat valid/ready register bus; request launches one cycle after its buffers fill.
// AW/W/AR readys drop while their one-entry buffer is full; the reg bus waits on reg_ready_i or the optional timeout.
module axi_lite_reg_bridge #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  AXI_LITE.Slave                      slv,
  output logic                        reg_valid_o,
  input  logic                        reg_ready_i,
  output logic                        reg_write_o,
  output logic [AXI_ADDR_WIDTH-1:0]   reg_addr_o,
  output logic [AXI_DATA_WIDTH-1:0]   reg_wdata_o,
  output logic [AXI_DATA_WIDTH/8-1:0] reg_wstrb_o,
  input  logic [AXI_DATA_WIDTH-1:0]   reg_rdata_i,
  input  logic                        reg_error_i
);

  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
  localparam int unsigned LSB    = $clog2(STRB_W);
  localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_MASK = {{(AXI_ADDR_WIDTH-LSB){1'b1}}, {LSB{1'b0}}};

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, ACCESS, WRESP, RRESP} state_e;

  typedef struct packed {
    logic                      write;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [AXI_DATA_WIDTH-1:0] wdata;
    logic [STRB_W-1:0]         wstrb;
  } reg_req_t;

  state_e                    state_q, state_d;
  logic                      prio_wr_q, prio_wr_d;
  logic                      aw_full_q, aw_full_d;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic                      w_full_q, w_full_d;
  logic [AXI_DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_W-1:0]         w_strb_q, w_strb_d;
  logic                      ar_full_q, ar_full_d;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic                      aw_ready_q, aw_ready_d;
  logic                      w_ready_q, w_ready_d;
  logic                      ar_ready_q, ar_ready_d;
  logic                      reg_valid_q, reg_valid_d;
  reg_req_t                  req_q, req_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      b_valid_q, b_valid_d;
  logic [1:0]                b_resp_q, b_resp_d;
  logic                      r_valid_q, r_valid_d;
  logic [1:0]                r_resp_q, r_resp_d;
  logic [AXI_DATA_WIDTH-1:0] r_data_q, r_data_d;

  logic       wr_pend, rd_pend, launch_wr, launch_rd;
  logic [1:0] resp;
  logic       unused_prot;

  assign unused_prot = ^{slv.aw_prot, slv.ar_prot};

  always_comb begin
    state_d     = state_q;
    prio_wr_d   = prio_wr_q;
    aw_full_d   = aw_full_q;
    aw_addr_d   = aw_addr_q;
    w_full_d    = w_full_q;
    w_data_d    = w_data_q;
    w_strb_d    = w_strb_q;
    ar_full_d   = ar_full_q;
    ar_addr_d   = ar_addr_q;
    reg_valid_d = reg_valid_q;
    req_d       = req_q;
    cnt_d       = cnt_q;
    b_valid_d   = b_valid_q;
    b_resp_d    = b_resp_q;
    r_valid_d   = r_valid_q;
    r_resp_d    = r_resp_q;
    r_data_d    = r_data_q;
    resp        = RESP_OKAY;
    wr_pend     = aw_full_q && w_full_q;
    rd_pend     = ar_full_q;
    launch_wr   = 1'b0;
    launch_rd   = 1'b0;

    // Accepting needs ready_q, launching needs full_q, so they never coincide on one buffer.
    if (slv.aw_valid && aw_ready_q) begin
      aw_full_d = 1'b1;
      aw_addr_d = slv.aw_addr & ADDR_MASK;
    end
    if (slv.w_valid && w_ready_q) begin
      w_full_d = 1'b1;
      w_data_d = slv.w_data;
      w_strb_d = slv.w_strb;
    end
    if (slv.ar_valid && ar_ready_q) begin
      ar_full_d = 1'b1;
      ar_addr_d = slv.ar_addr & ADDR_MASK;
    end

    unique case (state_q)
      IDLE: begin
        launch_wr = wr_pend && (prio_wr_q || !rd_pend);
        launch_rd = rd_pend && !launch_wr;
        if (wr_pend && rd_pend) begin
          prio_wr_d = !prio_wr_q;
        end
        if (launch_wr) begin
          aw_full_d   = 1'b0;
          w_full_d    = 1'b0;
          reg_valid_d = 1'b1;
          req_d       = '{write: 1'b1, addr: aw_addr_q, wdata: w_data_q, wstrb: w_strb_q};
          cnt_d       = '0;
          state_d     = ACCESS;
        end else if (launch_rd) begin
          ar_full_d   = 1'b0;
          reg_valid_d = 1'b1;
          req_d       = '{write: 1'b0, addr: ar_addr_q, wdata: '0, wstrb: '0};
          cnt_d       = '0;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (reg_ready_i) begin
          resp        = reg_error_i ? RESP_SLVERR : RESP_OKAY;
          reg_valid_d = 1'b0;
          req_d       = '0;
          if (req_q.write) begin
            b_valid_d = 1'b1;
            b_resp_d  = resp;
            state_d   = WRESP;
          end else begin
            r_valid_d = 1'b1;
            r_resp_d  = resp;
            r_data_d  = reg_rdata_i;
            state_d   = RRESP;
          end
        end else if (TIMEOUT_CYCLES > 0) begin
          if (cnt_q == CNT_LAST) begin
            reg_valid_d = 1'b0;
            req_d       = '0;
            if (req_q.write) begin
              b_valid_d = 1'b1;
              b_resp_d  = RESP_DECERR;
              state_d   = WRESP;
            end else begin
              r_valid_d = 1'b1;
              r_resp_d  = RESP_DECERR;
              r_data_d  = '0;
              state_d   = RRESP;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WRESP: begin
        if (slv.b_ready) begin
          b_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      RRESP: begin
        if (slv.r_ready) begin
          r_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    aw_ready_d = !aw_full_d;
    w_ready_d  = !w_full_d;
    ar_ready_d = !ar_full_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      prio_wr_q   <= 1'b1;
      aw_full_q   <= 1'b0;
      aw_addr_q   <= '0;
      w_full_q    <= 1'b0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      ar_full_q   <= 1'b0;
      ar_addr_q   <= '0;
      aw_ready_q  <= 1'b0;
      w_ready_q   <= 1'b0;
      ar_ready_q  <= 1'b0;
      reg_valid_q <= 1'b0;
      req_q       <= '0;
      cnt_q       <= '0;
      b_valid_q   <= 1'b0;
      b_resp_q    <= '0;
      r_valid_q   <= 1'b0;
      r_resp_q    <= '0;
      r_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      prio_wr_q   <= prio_wr_d;
      aw_full_q   <= aw_full_d;
      aw_addr_q   <= aw_addr_d;
      w_full_q    <= w_full_d;
      w_data_q    <= w_data_d;
      w_strb_q    <= w_strb_d;
      ar_full_q   <= ar_full_d;
      ar_addr_q   <= ar_addr_d;
      aw_ready_q  <= aw_ready_d;
      w_ready_q   <= w_ready_d;
      ar_ready_q  <= ar_ready_d;
      reg_valid_q <= reg_valid_d;
      req_q       <= req_d;
      cnt_q       <= cnt_d;
      b_valid_q   <= b_valid_d;
      b_resp_q    <= b_resp_d;
      r_valid_q   <= r_valid_d;
      r_resp_q    <= r_resp_d;
      r_data_q    <= r_data_d;
    end
  end

  assign slv.aw_ready = aw_ready_q;
  assign slv.w_ready  = w_ready_q;
  assign slv.ar_ready = ar_ready_q;
  assign slv.b_valid  = b_valid_q;
  assign slv.b_resp   = b_resp_q;
  assign slv.r_valid  = r_valid_q;
  assign slv.r_resp   = r_resp_q;
  assign slv.r_data   = r_data_q;

  assign reg_valid_o = reg_valid_q;
  assign reg_write_o = req_q.write;
  assign reg_addr_o  = req_q.addr;
  assign reg_wdata_o = req_q.wdata;
  assign reg_wstrb_o = req_q.wstrb;

endmodule

// File: tb/tb_axi_lite_reg_bridge.sv
// Directed bench for axi_lite_reg_bridge with a 4-cycle access timeout.
module tb_axi_lite_reg_bridge;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            reg_valid_o, reg_ready_i, reg_write_o, reg_error_i;
  logic [AW-1:0]   reg_addr_o;
  logic [DW-1:0]   reg_wdata_o, reg_rdata_i;
  logic [DW/8-1:0] reg_wstrb_o;

  int n_checks = 0;
  int n_fail   = 0;

  AXI_LITE #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) axi ();

  axi_lite_reg_bridge #(
    .AXI_ADDR_WIDTH(AW),
    .AXI_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .slv         (axi),
    .reg_valid_o (reg_valid_o),
    .reg_ready_i (reg_ready_i),
    .reg_write_o (reg_write_o),
    .reg_addr_o  (reg_addr_o),
    .reg_wdata_o (reg_wdata_o),
    .reg_wstrb_o (reg_wstrb_o),
    .reg_rdata_i (reg_rdata_i),
    .reg_error_i (reg_error_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    axi.aw_valid = 1'b0; axi.aw_addr = '0; axi.aw_prot = '0;
    axi.w_valid  = 1'b0; axi.w_data  = '0; axi.w_strb  = '0;
    axi.ar_valid = 1'b0; axi.ar_addr = '0; axi.ar_prot = '0;
    axi.b_ready  = 1'b0; axi.r_ready = 1'b0;
    reg_ready_i  = 1'b0; reg_error_i = 1'b0; reg_rdata_i = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " readys"}, {axi.aw_ready, axi.w_ready, axi.ar_ready}, 0);
    check({tag, " b/r"}, {axi.b_valid, axi.b_resp, axi.r_valid, axi.r_resp}, 0);
    check({tag, " r_data"}, axi.r_data, 0);
    check({tag, " reg ctl"}, {reg_valid_o, reg_write_o, reg_wstrb_o}, 0);
    check({tag, " reg addr"}, reg_addr_o, 0);
    check({tag, " reg wdata"}, reg_wdata_o, 0);
  endtask

  // Waits (bounded) for a launch, checks its kind and address, accepts it and drains the response.
  task automatic serve(input string tag, input logic exp_write, input logic [AW-1:0] exp_addr);
    int n = 0;
    while (!reg_valid_o && n < 20) begin
      tick();
      n++;
    end
    check({tag, " launched"}, reg_valid_o, 1);
    check({tag, " write"}, reg_write_o, exp_write);
    check({tag, " addr"}, reg_addr_o, exp_addr);
    reg_ready_i = 1'b1;
    tick();
    reg_ready_i = 1'b0;
    if (exp_write) begin
      check({tag, " b_valid"}, {axi.b_valid, axi.b_resp}, 3'b100);
      axi.b_ready = 1'b1;
      tick();
      axi.b_ready = 1'b0;
      check({tag, " b done"}, axi.b_valid, 0);
    end else begin
      check({tag, " r_valid"}, {axi.r_valid, axi.r_resp}, 3'b100);
      axi.r_ready = 1'b1;
      tick();
      axi.r_ready = 1'b0;
      check({tag, " r done"}, axi.r_valid, 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst_i = 1'b1;
    tick();
    check_all_zero("reset");
    tick();
    rst_i = 1'b0;
    tick();
    check("readys after reset", {axi.aw_ready, axi.w_ready, axi.ar_ready}, 3'b111);

    // Single write, AW and W together, ready on the first valid cycle.
    axi.aw_valid = 1'b1; axi.aw_addr = 32'h1004;
    axi.w_valid  = 1'b1; axi.w_data  = 32'hDEADBEEF; axi.w_strb = 4'hF;
    tick();
    axi.aw_valid = 1'b0; axi.w_valid = 1'b0;
    check("wr1 readys low", {axi.aw_ready, axi.w_ready}, 0);
    check("wr1 not yet valid", reg_valid_o, 0);
    tick();
    check("wr1 valid", reg_valid_o, 1);
    check("wr1 write", reg_write_o, 1);
    check("wr1 addr", reg_addr_o, 32'h1004);
    check("wr1 wdata", reg_wdata_o, 32'hDEADBEEF);
    check("wr1 wstrb", reg_wstrb_o, 4'hF);
    reg_ready_i = 1'b1;
    tick();
    reg_ready_i = 1'b0;
    check("wr1 valid one cycle", {reg_valid_o, reg_write_o, reg_wstrb_o}, 0);
    check("wr1 b_valid", {axi.b_valid, axi.b_resp}, 3'b100);
    tick();
    check("wr1 b held", axi.b_valid, 1);
    axi.b_ready = 1'b1;
    tick();
    axi.b_ready = 1'b0;
    check("wr1 b done", axi.b_valid, 0);

    // W three cycles ahead of an unaligned AW.
    axi.w_valid = 1'b1; axi.w_data = 32'hCAFE0001; axi.w_strb = 4'h3;
    tick();
    axi.w_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check("wfirst no valid", reg_valid_o, 0);
      check("wfirst w_ready low", axi.w_ready, 0);
      if (c == 3) begin
        axi.aw_valid = 1'b1; axi.aw_addr = 32'h1007;
      end
      tick();
    end
    axi.aw_valid = 1'b0;
    check("wfirst no valid c4", reg_valid_o, 0);
    check("wfirst w_ready low c4", axi.w_ready, 0);
    tick();
    check("wfirst valid", reg_valid_o, 1);
    check("wfirst wdata", reg_wdata_o, 32'hCAFE0001);
    check("wfirst wstrb", reg_wstrb_o, 4'h3);
    check("wfirst w_ready after launch", axi.w_ready, 1);
    serve("wfirst", 1'b1, 32'h1004);

    // Read answered with an error; response held while r_ready is low.
    axi.ar_valid = 1'b1; axi.ar_addr = 32'h20;
    tick();
    axi.ar_valid = 1'b0;
    check("rd ar_ready low", axi.ar_ready, 0);
    tick();
    check("rd valid", {reg_valid_o, reg_write_o}, 2'b10);
    check("rd addr", reg_addr_o, 32'h20);
    check("rd wstrb", reg_wstrb_o, 0);
    reg_ready_i = 1'b1; reg_error_i = 1'b1; reg_rdata_i = 32'h55;
    tick();
    reg_ready_i = 1'b0; reg_error_i = 1'b0; reg_rdata_i = 32'hFFFFFFFF;
    for (int i = 0; i < 6; i++) begin
      check("rd r_valid", axi.r_valid, 1);
      check("rd r_resp", axi.r_resp, 2'b10);
      check("rd r_data", axi.r_data, 32'h55);
      if (i < 5) tick();
    end
    axi.r_ready = 1'b1;
    tick();
    axi.r_ready = 1'b0;
    check("rd r done", axi.r_valid, 0);

    // Arbitration: write wins after reset, then read wins the next tie.
    idle_inputs();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tick();
    axi.aw_valid = 1'b1; axi.aw_addr = 32'h100; axi.w_valid = 1'b1; axi.w_data = 32'h11; axi.w_strb = 4'hF;
    axi.ar_valid = 1'b1; axi.ar_addr = 32'h200;
    tick();
    idle_inputs();
    serve("arb1 first", 1'b1, 32'h100);
    serve("arb1 second", 1'b0, 32'h200);
    axi.aw_valid = 1'b1; axi.aw_addr = 32'h104; axi.w_valid = 1'b1; axi.w_data = 32'h22; axi.w_strb = 4'hF;
    axi.ar_valid = 1'b1; axi.ar_addr = 32'h204;
    tick();
    idle_inputs();
    serve("arb2 first", 1'b0, 32'h204);
    serve("arb2 second", 1'b1, 32'h104);

    // Timeout with no ready, then ready exactly on the last allowed cycle.
    reg_rdata_i = 32'hA5A5A5A5;
    axi.ar_valid = 1'b1; axi.ar_addr = 32'h40;
    tick();
    axi.ar_valid = 1'b0;
    tick();
    for (int i = 0; i < TMO; i++) begin
      check("tmo valid held", reg_valid_o, 1);
      tick();
    end
    check("tmo valid dropped", reg_valid_o, 0);
    check("tmo r_valid", axi.r_valid, 1);
    check("tmo r_resp", axi.r_resp, 2'b11);
    check("tmo r_data", axi.r_data, 0);
    axi.r_ready = 1'b1;
    tick();
    axi.r_ready = 1'b0;
    axi.ar_valid = 1'b1; axi.ar_addr = 32'h44;
    tick();
    axi.ar_valid = 1'b0;
    tick();
    for (int i = 0; i < TMO - 1; i++) begin
      check("tmo2 valid held", reg_valid_o, 1);
      tick();
    end
    check("tmo2 valid last", reg_valid_o, 1);
    reg_ready_i = 1'b1; reg_rdata_i = 32'h1234;
    tick();
    reg_ready_i = 1'b0;
    check("tmo2 r_valid", axi.r_valid, 1);
    check("tmo2 r_resp", axi.r_resp, 2'b00);
    check("tmo2 r_data", axi.r_data, 32'h1234);
    axi.r_ready = 1'b1;
    tick();
    axi.r_ready = 1'b0;

    // Reset during an access with a read also buffered.
    axi.aw_valid = 1'b1; axi.aw_addr = 32'h300; axi.w_valid = 1'b1; axi.w_data = 32'h77; axi.w_strb = 4'hF;
    tick();
    axi.aw_valid = 1'b0; axi.w_valid = 1'b0;
    tick();
    check("mid valid", reg_valid_o, 1);
    axi.ar_valid = 1'b1; axi.ar_addr = 32'h400;
    tick();
    axi.ar_valid = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_all_zero("mid reset");
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post reset quiet", {reg_valid_o, axi.b_valid, axi.r_valid}, 0);
    end
    axi.aw_valid = 1'b1; axi.aw_addr = 32'h500; axi.w_valid = 1'b1; axi.w_data = 32'h99; axi.w_strb = 4'hF;
    tick();
    axi.aw_valid = 1'b0; axi.w_valid = 1'b0;
    serve("post reset wr", 1'b1, 32'h500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
